// File: rtl/bolme_birimi_pkg.sv
// bolme_birimi_pkg: shared widths, operation codes and FSM states for the RV32M divider.
package bolme_birimi_pkg;
    localparam int VERI_W  = 32;
    localparam int SAYAC_W = 5;

    localparam logic [1:0] BOLME_DIV  = 2'b00;
    localparam logic [1:0] BOLME_DIVU = 2'b01;
    localparam logic [1:0] BOLME_REM  = 2'b10;
    localparam logic [1:0] BOLME_REMU = 2'b11;

    typedef enum logic [1:0] {
        BOSTA = 2'b00,
        BOL   = 2'b01,
        BITIR = 2'b10
    } durum_e;
endpackage

// File: rtl/bolme_birimi_adimi.sv
// bolme_birimi_adimi: one combinational restoring-division step on remainder/quotient pair.
module bolme_birimi_adimi
    import bolme_birimi_pkg::*;
(
    input  logic [VERI_W-1:0] kalan,
    input  logic [VERI_W-1:0] bolum,
    input  logic [VERI_W-1:0] bolen,
    output logic [VERI_W-1:0] kalan_n,
    output logic [VERI_W-1:0] bolum_n
);
    logic [VERI_W:0] fark;

    // A borrow in the top bit means the trial subtraction failed; keep the shifted remainder.
    always_comb begin
        fark    = {kalan, bolum[VERI_W-1]} - {1'b0, bolen};
        kalan_n = fark[VERI_W] ? {kalan[VERI_W-2:0], bolum[VERI_W-1]} : fark[VERI_W-1:0];
        bolum_n = {bolum[VERI_W-2:0], ~fark[VERI_W]};
    end
endmodule

// File: rtl/bolme_birimi.sv
// bolme_birimi: iterative radix-2 divider for DIV/DIVU/REM/REMU with 1-cycle special cases.
module bolme_birimi
    import bolme_birimi_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              basla_i,
    input  logic              iptal_i,
    input  logic              durdur_i,
    input  logic [1:0]        kontrol_i,
    input  logic [VERI_W-1:0] deger1_i,
    input  logic [VERI_W-1:0] deger2_i,
    output logic [VERI_W-1:0] sonuc_o,
    output logic              gecerli_o,
    output logic              mesgul_o
);
    durum_e durum, durum_n;
    logic [SAYAC_W-1:0] sayac;
    logic [VERI_W-1:0]  kalan, bolum, bolen, kalan_n, bolum_n;
    logic [VERI_W-1:0]  mag_a, mag_b, ozel_sonuc, son_sonuc;
    logic               kalan_mi, sa, sb, sa_n, sb_n, bolen_sifir, tasma, ozel, kabul;

    bolme_birimi_adimi u_adim (
        .kalan   (kalan),
        .bolum   (bolum),
        .bolen   (bolen),
        .kalan_n (kalan_n),
        .bolum_n (bolum_n)
    );

    // Signed ops divide magnitudes; INT_MIN negates to itself, which is the right unsigned magnitude.
    always_comb begin
        sa_n        = ~kontrol_i[0] & deger1_i[VERI_W-1];
        sb_n        = ~kontrol_i[0] & deger2_i[VERI_W-1];
        mag_a       = sa_n ? -deger1_i : deger1_i;
        mag_b       = sb_n ? -deger2_i : deger2_i;
        bolen_sifir = deger2_i == '0;
        tasma       = ~kontrol_i[0] & (deger1_i == {1'b1, {(VERI_W-1){1'b0}}}) & (&deger2_i);
        ozel        = bolen_sifir | tasma;
        ozel_sonuc  = bolen_sifir ? (kontrol_i[1] ? deger1_i : '1)
                                  : (kontrol_i[1] ? '0 : {1'b1, {(VERI_W-1){1'b0}}});
        son_sonuc   = kalan_mi ? (sa ? -kalan_n : kalan_n) : ((sa ^ sb) ? -bolum_n : bolum_n);
        kabul       = (durum == BOSTA) & basla_i & ~iptal_i;
    end

    always_comb begin
        durum_n = durum;
        case (durum)
            BOSTA:   durum_n = basla_i ? (ozel ? BITIR : BOL) : BOSTA;
            BOL:     durum_n = (sayac == '0) ? BITIR : BOL;
            BITIR:   durum_n = durdur_i ? BITIR : BOSTA;
            default: durum_n = BOSTA;
        endcase
        if (iptal_i) durum_n = BOSTA;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) durum <= BOSTA;
        else         durum <= durum_n;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sonuc_o  <= '0;
            sayac    <= '0;
            kalan    <= '0;
            bolum    <= '0;
            bolen    <= '0;
            kalan_mi <= 1'b0;
            sa       <= 1'b0;
            sb       <= 1'b0;
        end else if (kabul) begin
            kalan_mi <= kontrol_i[1];
            sa       <= sa_n;
            sb       <= sb_n;
            bolen    <= mag_b;
            if (ozel) begin
                sonuc_o <= ozel_sonuc;
            end else begin
                sayac <= SAYAC_W'(VERI_W - 1);
                kalan <= '0;
                bolum <= mag_a;
            end
        end else if (durum == BOL && !iptal_i) begin
            kalan <= kalan_n;
            bolum <= bolum_n;
            sayac <= sayac - SAYAC_W'(1);
            if (sayac == '0) sonuc_o <= son_sonuc;
        end
    end

    assign gecerli_o = durum == BITIR;
    assign mesgul_o  = durum != BOSTA;
endmodule
